// File: rtl/cam_pack_pkg.sv
// Shared types, default widths and the beats-per-pixel helper for the camera pixel packer.
package cam_pack_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int MAX_BPP_DEF = 3;
  localparam int X_W_DEF     = 12;
  localparam int Y_W_DEF     = 12;
  localparam int PH_W        = 2;

  typedef enum logic [1:0] {
    CAM_RAW8   = 2'd0,
    CAM_RGB565 = 2'd1,
    CAM_RGB888 = 2'd2,
    CAM_RSVD   = 2'd3
  } cam_mode_e;

  // The reserved mode packs like RGB565.
  function automatic logic [PH_W-1:0] bpp(input cam_mode_e m);
    case (m)
      CAM_RAW8:   return 2'd1;
      CAM_RGB888: return 2'd3;
      default:    return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/cam_pos_counter.sv
// Frame/line position tracking: sync edge detection, saturating column/row counters,
// start-of-frame/line pending flags and the completed-frame counter.
module cam_pos_counter #(
  parameter int X_W = 12,
  parameter int Y_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           vs_in,
  input  logic           hr_in,
  input  logic           pix_done,
  input  logic           pix_emit,
  output logic           vs_rise,
  output logic           hr_rise,
  output logic           hr_fall,
  output logic           frame_active,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           sof_pend,
  output logic           sol_pend,
  output logic [15:0]    frame_cnt
);

  localparam logic [X_W-1:0] X_ONE = 1;
  localparam logic [Y_W-1:0] Y_ONE = 1;

  logic           vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
  logic           active_q, active_d, sof_q, sof_d, sol_q, sol_d;
  logic           line_pix_q, line_pix_d, line_pix, vs_fall;
  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  // Outputs are the "effective" values for this cycle, so an edge and a beat in
  // the same cycle see the freshly cleared column/row/phase.
  always_comb begin
    vs_prev_d    = vs_in;
    hr_prev_d    = hr_in;
    vs_rise      = vs_in & ~vs_prev_q;
    vs_fall      = ~vs_in & vs_prev_q;
    hr_rise      = hr_in & ~hr_prev_q;
    hr_fall      = ~hr_in & hr_prev_q;
    frame_active = active_q;
    col          = hr_rise ? '0 : col_q;
    row          = vs_rise ? '0 : row_q;
    sof_pend     = sof_q | vs_rise;
    sol_pend     = sol_q | hr_rise;
    line_pix     = line_pix_q & ~hr_rise & ~vs_rise;
    active_d     = active_q | vs_rise;
    col_d        = (pix_done && (col != '1)) ? col + X_ONE : col;
    row_d        = (hr_fall && line_pix && (row != '1)) ? row + Y_ONE : row;
    sof_d        = sof_pend & ~pix_emit;
    sol_d        = sol_pend & ~pix_emit;
    line_pix_d   = line_pix | pix_done;
    frame_cnt_d  = frame_cnt_q + {15'd0, vs_fall & en};
    frame_cnt    = frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      vs_prev_q  <= 1'b0;
      hr_prev_q  <= 1'b0;
      active_q   <= 1'b0;
      sof_q      <= 1'b0;
      sol_q      <= 1'b0;
      line_pix_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      vs_prev_q  <= vs_prev_d;
      hr_prev_q  <= hr_prev_d;
      active_q   <= active_d;
      sof_q      <= sof_d;
      sol_q      <= sol_d;
      line_pix_q <= line_pix_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
    // The frame count survives a sensor-idle period; only a real reset clears it.
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

endmodule

// File: rtl/cam_pixel_packer.sv
// Camera byte-stream to pixel packer (RAW8/RGB565/RGB888) with X/Y, SOF/SOL and line errors.
// Optional crop window enabled by defining CAM_PACK_CROP_EN.
module cam_pixel_packer
  import cam_pack_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_BPP = MAX_BPP_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      cam_vsync,
  input  logic                      cam_href,
  input  logic [DATA_W-1:0]         cam_data,
`ifdef CAM_PACK_CROP_EN
  input  logic [X_W-1:0]            crop_x0,
  input  logic [X_W-1:0]            crop_x1,
  input  logic [Y_W-1:0]            crop_y0,
  input  logic [Y_W-1:0]            crop_y1,
`endif
  output logic                      pix_valid,
  output logic [DATA_W*MAX_BPP-1:0] pix_data,
  output logic                      pix_sof,
  output logic                      pix_sol,
  output logic [X_W-1:0]            pix_x,
  output logic [Y_W-1:0]            pix_y,
  output logic                      line_err,
  output logic [15:0]               frame_cnt
);

  localparam int OUT_W = DATA_W * MAX_BPP;

  logic              vs_q, vs_d, hr_q, hr_d;
  logic [DATA_W-1:0] data_q, data_d;
  cam_mode_e         mode_q, mode_d;
  logic [PH_W-1:0]   phase_q, phase_d, phase;
  logic [OUT_W-1:0]  acc_q, acc_d, acc_next;
  logic              beat, last, emit, in_win;
  logic              vs_rise, hr_rise, hr_fall, frame_active, sof_pend, sol_pend;
  logic [X_W-1:0]    col;
  logic [Y_W-1:0]    row;

  logic              pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d, pix_sol_q, pix_sol_d;
  logic              line_err_q, line_err_d;
  logic [OUT_W-1:0]  pix_data_q, pix_data_d;
  logic [X_W-1:0]    pix_x_q, pix_x_d;
  logic [Y_W-1:0]    pix_y_q, pix_y_d;

  cam_pos_counter #(.X_W(X_W), .Y_W(Y_W)) u_pos (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .vs_in        (vs_q),
    .hr_in        (hr_q),
    .pix_done     (last),
    .pix_emit     (emit),
    .vs_rise      (vs_rise),
    .hr_rise      (hr_rise),
    .hr_fall      (hr_fall),
    .frame_active (frame_active),
    .col          (col),
    .row          (row),
    .sof_pend     (sof_pend),
    .sol_pend     (sol_pend),
    .frame_cnt    (frame_cnt)
  );

`ifdef CAM_PACK_CROP_EN
  logic [X_W-1:0] cx0_q, cx0_d, cx1_q, cx1_d;
  logic [Y_W-1:0] cy0_q, cy0_d, cy1_q, cy1_d;

  always_comb begin
    cx0_d  = vs_rise ? crop_x0 : cx0_q;
    cx1_d  = vs_rise ? crop_x1 : cx1_q;
    cy0_d  = vs_rise ? crop_y0 : cy0_q;
    cy1_d  = vs_rise ? crop_y1 : cy1_q;
    in_win = (col >= cx0_q) && (col <= cx1_q) && (row >= cy0_q) && (row <= cy1_q);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cx0_q <= '0;
      cx1_q <= '0;
      cy0_q <= '0;
      cy1_q <= '0;
    end else begin
      cx0_q <= cx0_d;
      cx1_q <= cx1_d;
      cy0_q <= cy0_d;
      cy1_q <= cy1_d;
    end
  end
`else
  assign in_win = 1'b1;
`endif

  always_comb begin
    vs_d   = cam_vsync;
    hr_d   = cam_href;
    data_d = cam_data;
    mode_d = vs_rise ? cam_mode_e'(mode) : mode_q;
    phase  = (vs_rise || hr_rise) ? '0 : phase_q;
    beat   = hr_q & ~vs_q & frame_active;
    last   = beat && (phase == bpp(mode_q) - 2'd1);
    // Earlier beats shift up so the first beat ends up most significant.
    acc_next = ((phase == '0) ? '0 : (acc_q << DATA_W)) | OUT_W'(data_q);
    acc_d    = beat ? acc_next : acc_q;
    phase_d  = phase;
    if (beat)         phase_d = last ? '0 : phase + 2'd1;
    else if (hr_fall) phase_d = '0;
    emit        = last & in_win;
    pix_valid_d = emit;
    pix_data_d  = emit ? acc_next : '0;
    pix_x_d     = emit ? col : '0;
    pix_y_d     = emit ? row : '0;
    pix_sof_d   = emit & sof_pend;
    pix_sol_d   = emit & sol_pend;
    line_err_d  = hr_fall & (phase != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      data_q      <= '0;
      mode_q      <= CAM_RGB565;
      phase_q     <= '0;
      acc_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_sof_q   <= 1'b0;
      pix_sol_q   <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      vs_q        <= vs_d;
      hr_q        <= hr_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_sof_q   <= pix_sof_d;
      pix_sol_q   <= pix_sol_d;
      line_err_q  <= line_err_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_sof   = pix_sof_q;
  assign pix_sol   = pix_sol_q;
  assign line_err  = line_err_q;

endmodule
